// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b register index, scoreboard entry type and forward-select names
package lc3b_types;
  localparam int LC3B_REG_W = 3;
  typedef logic [LC3B_REG_W-1:0] lc3b_reg;
  typedef struct packed {
    logic    valid;
    lc3b_reg dr;
    logic    is_load;
  } sb_entry_t;
  localparam int FWD_REGFILE = 0;
  localparam int FWD_EX_MEM  = 1;
  localparam int FWD_MEM_WB  = 2;
endpackage

// File: rtl/fwd_priority_select.sv
// fwd_priority_select: returns the lowest-index set match bit (entry k = bit k-1) as a forward select, regfile if none
module fwd_priority_select
  import lc3b_types::*;
#(
  parameter int DEPTH = 3,
  parameter int SEL_W = $clog2(DEPTH + 1)
) (
  input  logic [DEPTH-1:0] match,
  output logic [SEL_W-1:0] sel
);
  always_comb begin
    sel = SEL_W'(FWD_REGFILE);
    for (int k = DEPTH; k >= 1; k--) sel = match[k-1] ? SEL_W'(k) : sel;
  end
endmodule

// File: rtl/forwarding_scoreboard.sv
// forwarding_scoreboard: shift-register scoreboard of in-flight writes giving youngest-producer forward selects, load-use stall and a saturating stall counter
module forwarding_scoreboard
  import lc3b_types::*;
#(
  parameter int REG_W       = 3,
  parameter int NUM_SRC     = 2,
  parameter int DEPTH       = 3,
  parameter int ZERO_REG_HW = 0,
  parameter int SEL_W       = $clog2(DEPTH + 1),
  parameter int CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     advance,
  input  logic                     flush,
  input  logic                     ex_valid,
  input  logic                     ex_load_regfile,
  input  logic                     ex_is_load,
  input  logic [REG_W-1:0]         ex_dr,
  input  logic [NUM_SRC*REG_W-1:0] ex_src,
  input  logic [NUM_SRC-1:0]       ex_src_used,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic                     load_use_stall,
  output logic [CNT_W-1:0]         stall_count
);
  sb_entry_t sb_q [1:DEPTH];
  logic [NUM_SRC*DEPTH-1:0] match;
  logic [NUM_SRC-1:0] hazard;
  logic stall_adv_q;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [REG_W-1:0] src;
    assign src = ex_src[i*REG_W +: REG_W];
    for (genvar k = 1; k <= DEPTH; k++) begin : g_ent
      assign match[i*DEPTH+k-1] = sb_q[k].valid & ex_src_used[i] & (sb_q[k].dr == lc3b_reg'(src))
                                  & ~((ZERO_REG_HW != 0) && (src == '0));
    end
    assign hazard[i] = match[i*DEPTH] & sb_q[1].is_load;
    fwd_priority_select #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_sel (
      .match(match[i*DEPTH +: DEPTH]),
      .sel  (fwd_sel[i*SEL_W +: SEL_W])
    );
  end
  assign load_use_stall = ex_valid & ~flush & (|hazard);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) sb_q[k] <= '0;
      stall_count <= '0;
      stall_adv_q <= 1'b0;
    end else if (advance) begin
      sb_q[1] <= '{valid: ex_valid & ex_load_regfile & ~flush & ~load_use_stall,
                   dr: lc3b_reg'(ex_dr), is_load: ex_is_load};
      for (int k = 2; k <= DEPTH; k++) sb_q[k] <= sb_q[k-1];
      if (load_use_stall && !(&stall_count)) stall_count <= stall_count + 1'b1;
      stall_adv_q <= load_use_stall;
    end
  end
  // the bubble inserted by a stall means the same consumer can never hazard on the following advance
  a_single_bubble: assert property (@(posedge clk) disable iff (!rst_n)
    !(stall_adv_q && advance && load_use_stall));
endmodule
